// File: rtl/ad_capture_ctrl_if.sv
// Pin- and buffer-side signal bundle of the dual-channel ADC capture controller.
// The controller connects through the master modport; the ADC/PLL/RAM side sees slave.
interface ad_capture_ctrl_if #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 10,
   parameter int OTR_W  = 16
);
   logic                pll_lock;
   logic                start;
   logic                abort;
   logic [1:0]          trig_mode;
   logic [DATA_W-1:0]   trig_level;
   logic [DATA_W-1:0]   ad_data1;
   logic [DATA_W-1:0]   ad_data2;
   logic                OTR1;
   logic                OTR2;
   logic                ad_oe_n;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [2*DATA_W-1:0] wr_data;
   logic                busy;
   logic                done;
   logic                lock_err;
   logic [OTR_W-1:0]    otr_cnt;

   modport master (
      input  pll_lock, start, abort, trig_mode, trig_level,
      input  ad_data1, ad_data2, OTR1, OTR2,
      output ad_oe_n, wr_en, wr_addr, wr_data, busy, done, lock_err, otr_cnt
   );

   modport slave (
      output pll_lock, start, abort, trig_mode, trig_level,
      output ad_data1, ad_data2, OTR1, OTR2,
      input  ad_oe_n, wr_en, wr_addr, wr_data, busy, done, lock_err, otr_cnt
   );
endinterface

// File: rtl/ad_capture_ctrl.sv
// Dual-channel ADC capture sequencer: PLL-lock gating of the ADC output enables,
// arm/trigger on channel 1, then CAP_LEN paired {ch2,ch1} writes into the buffer.
module ad_capture_ctrl #(
   parameter int DATA_W    = 10,
   parameter int ADDR_W    = 10,
   parameter int CAP_LEN   = 1024,
   parameter int LOCK_WAIT = 255,
   parameter int OTR_W     = 16
) (
   input  logic              clk_20M,
   input  logic              rst_n,
   ad_capture_ctrl_if.master bus
);

   localparam int LCNT_W = (LOCK_WAIT < 2) ? 1 : $clog2(LOCK_WAIT);
   localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_WAIT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CAP_LEN - 1);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [LCNT_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic                  oe_n_q, oe_n_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
   logic [2*DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                  done_q, done_d;
   logic                  lock_err_q, lock_err_d;
   logic [OTR_W-1:0]      otr_cnt_q, otr_cnt_d;
   logic                  lock_meta_q, lock_sync_q;
   logic                  vld_p1_q;
   logic [DATA_W-1:0]     s1_ch1_q, s1_ch2_q, p1_ch1_q;
   logic                  s1_otr_q;
   logic                  trig_hit_w;

   function automatic logic [OTR_W-1:0] sat_inc(input logic [OTR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic trig_eval(input logic [1:0]        mode,
                                      input logic              prev_vld,
                                      input logic [DATA_W-1:0] lvl,
                                      input logic [DATA_W-1:0] prev,
                                      input logic [DATA_W-1:0] cur);
      logic hit;
      case (mode)
         2'd1:    hit = prev_vld && (prev < lvl) && (lvl <= cur);
         2'd2:    hit = prev_vld && (prev >= lvl) && (lvl > cur);
         default: hit = 1'b1;
      endcase
      return hit;
   endfunction

   // Stage s1: raw pin capture; stage p1: previous s1 channel-1 sample
   always_ff @(posedge clk_20M) begin
      s1_ch1_q <= bus.ad_data1;
      s1_ch2_q <= bus.ad_data2;
      s1_otr_q <= bus.OTR1 | bus.OTR2;
      p1_ch1_q <= s1_ch1_q;
   end

   always_ff @(posedge clk_20M or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_sync_q <= lock_meta_q;
      end
   end

   // p1 only holds an armed-period sample after one full ARMED cycle
   assign trig_hit_w = trig_eval(bus.trig_mode, vld_p1_q, bus.trig_level, p1_ch1_q, s1_ch1_q);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      oe_n_d     = oe_n_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = done_q;
      lock_err_d = lock_err_q;
      otr_cnt_d  = otr_cnt_q;
      if ((state_q != S_WAIT_LOCK) && !lock_sync_q) begin
         state_d    = S_WAIT_LOCK;
         oe_n_d     = 1'b1;
         lock_cnt_d = '0;
         done_d     = 1'b0;
         if ((state_q == S_ARMED) || (state_q == S_CAPTURE)) lock_err_d = 1'b1;
      end else begin
         case (state_q)
            S_WAIT_LOCK: begin
               if (!lock_sync_q) begin
                  lock_cnt_d = '0;
               end else if (lock_cnt_q == LOCK_LAST) begin
                  state_d    = S_IDLE;
                  oe_n_d     = 1'b0;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
            S_IDLE, S_DONE: begin
               if (bus.start && !bus.abort) begin
                  state_d    = S_ARMED;
                  done_d     = 1'b0;
                  lock_err_d = 1'b0;
                  otr_cnt_d  = '0;
               end
            end
            S_ARMED: begin
               if (bus.abort) begin
                  state_d = S_IDLE;
               end else if (trig_hit_w) begin
                  state_d   = S_CAPTURE;
                  wr_en_d   = 1'b1;
                  wr_addr_d = '0;
                  wr_data_d = {s1_ch2_q, s1_ch1_q};
                  if (s1_otr_q) otr_cnt_d = sat_inc(otr_cnt_q);
               end
            end
            S_CAPTURE: begin
               if (bus.abort) begin
                  state_d = S_IDLE;
               end else if (wr_addr_q == ADDR_LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = wr_addr_q + 1'b1;
                  wr_data_d = {s1_ch2_q, s1_ch1_q};
                  if (s1_otr_q) otr_cnt_d = sat_inc(otr_cnt_q);
               end
            end
            default: state_d = S_WAIT_LOCK;
         endcase
      end
   end

   always_ff @(posedge clk_20M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_WAIT_LOCK;
         lock_cnt_q <= '0;
         oe_n_q     <= 1'b1;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         lock_err_q <= 1'b0;
         otr_cnt_q  <= '0;
         vld_p1_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         oe_n_q     <= oe_n_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         lock_err_q <= lock_err_d;
         otr_cnt_q  <= otr_cnt_d;
         vld_p1_q   <= (state_q == S_ARMED);
      end
   end

   assign bus.ad_oe_n  = oe_n_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign bus.done     = done_q;
   assign bus.lock_err = lock_err_q;
   assign bus.otr_cnt  = otr_cnt_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Directed + randomized bench for ad_capture_ctrl; captures are predicted from a
// per-edge history of the pins and the trigger/length rules.
`timescale 1ns/1ps
module tb_ad_capture_ctrl;
   localparam int DATA_W    = 10;
   localparam int ADDR_W    = 4;
   localparam int CAP_LEN   = 8;
   localparam int LOCK_WAIT = 10;
   localparam int OTR_W     = 2;
   localparam int OTR_MAX   = (1 << OTR_W) - 1;
   localparam int HN        = 8192;

   logic clk = 1'b0;
   logic rst_n;

   ad_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OTR_W(OTR_W)) bus ();

   ad_capture_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CAP_LEN(CAP_LEN),
      .LOCK_WAIT(LOCK_WAIT), .OTR_W(OTR_W)
   ) dut (
      .clk_20M(clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #25 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pin history indexed by the rising edge that sampled it
   int cyc = 0;
   int h1[HN];
   int h2[HN];
   int ho[HN];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      h1[(cyc + 1) % HN] <= int'(bus.ad_data1);
      h2[(cyc + 1) % HN] <= int'(bus.ad_data2);
      ho[(cyc + 1) % HN] <= int'(bus.OTR1 | bus.OTR2);
   end

   typedef struct { int e; int addr; int data; } wr_t;
   wr_t obs_q[$];
   always @(negedge clk)
      if (bus.wr_en === 1'b1) obs_q.push_back('{cyc, int'(bus.wr_addr), int'(bus.wr_data)});

   int pat = 0;
   int ramp = 0;
   int hold_v = 0;
   bit otr_force = 1'b0;
   bit otr_rand = 1'b0;

   function automatic int ix(input int e);
      return ((e % HN) + HN) % HN;
   endfunction

   // Reference trigger search: first edge after arming where the rule holds
   function automatic int find_trigger(input int a, input int mode, input int lvl, input int last);
      int cur, prev;
      for (int e = a + 1; e <= last; e++) begin
         cur  = h1[ix(e - 1)];
         prev = h1[ix(e - 2)];
         if (mode == 0 || mode == 3) return e;
         if (mode == 1 && e >= a + 2 && prev < lvl && lvl <= cur) return e;
         if (mode == 2 && e >= a + 2 && prev >= lvl && lvl > cur) return e;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit st = 1'b0, input bit ab = 1'b0);
      bus.start = st;
      bus.abort = ab;
      case (pat)
         0: bus.ad_data1 = DATA_W'($urandom_range(0, 1023));
         1: begin bus.ad_data1 = DATA_W'(ramp); ramp++; end
         2: begin bus.ad_data1 = DATA_W'(ramp); ramp--; end
         default: bus.ad_data1 = DATA_W'(hold_v);
      endcase
      bus.ad_data2 = DATA_W'($urandom_range(0, 1023));
      bus.OTR1 = otr_force | (otr_rand & ($urandom_range(0, 3) == 0));
      bus.OTR2 = otr_rand & ($urandom_range(0, 3) == 0);
      @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 400 && bus.done !== 1'b1; i++) tick();
      chk({tag, "_done"}, bus.done, 1);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   task automatic check_capture(input int a, input int mode, input int lvl, input string tag);
      int t, n, otr_sum;
      t = find_trigger(a, mode, lvl, cyc);
      n = (t < 0) ? 0 : CAP_LEN;
      chk({tag, "_nwr"}, obs_q.size(), n);
      for (int k = 0; k < n && k < obs_q.size(); k++) begin
         chk({tag, "_edge"}, obs_q[k].e, t + k);
         chk({tag, "_addr"}, obs_q[k].addr, k);
         chk({tag, "_data"}, obs_q[k].data, (h2[ix(t - 1 + k)] << DATA_W) | h1[ix(t - 1 + k)]);
      end
      otr_sum = 0;
      for (int k = 0; k < n; k++) otr_sum += ho[ix(t - 1 + k)];
      if (otr_sum > OTR_MAX) otr_sum = OTR_MAX;
      chk({tag, "_otr"}, bus.otr_cnt, otr_sum);
   endtask

   task automatic start_capture(input string tag, output int a);
      obs_q.delete();
      tick(1'b1);
      a = cyc;
      chk({tag, "_arm_busy"}, bus.busy, 1);
      chk({tag, "_arm_done"}, bus.done, 0);
      chk({tag, "_arm_otr"}, bus.otr_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a, mode, lvl;
      rst_n = 1'b0;
      bus.pll_lock = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.trig_mode = 2'd0;
      bus.trig_level = '0;
      bus.ad_data1 = '0;
      bus.ad_data2 = '0;
      bus.OTR1 = 1'b0;
      bus.OTR2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_oe_n", bus.ad_oe_n, 1);
      chk("rst_outs", {bus.wr_en, bus.busy, bus.done, bus.lock_err, bus.otr_cnt, bus.wr_addr, bus.wr_data}, 0);
      rst_n = 1'b1;

      // T1: enables stay off for LOCK_WAIT+2 cycles; start in WAIT_LOCK ignored
      for (int i = 1; i <= LOCK_WAIT + 1; i++) begin
         tick(i == 3);
         chk("t1_wait", {bus.ad_oe_n, bus.wr_en, bus.busy, bus.done, bus.lock_err}, 5'b10000);
      end
      tick();
      chk("t1_oe_on", bus.ad_oe_n, 0);
      chk("t1_busy", bus.busy, 0);

      // T2: mode 0 on a ramp, with an ignored start mid-capture
      pat = 1; ramp = 0; bus.trig_mode = 2'd0;
      tick();
      start_capture("t2", a);
      repeat (3) tick();
      tick(1'b1);
      wait_done("t2");
      check_capture(a, 0, 0, "t2");

      // T3: rising crossing at 512
      pat = 1; ramp = 500; bus.trig_mode = 2'd1; bus.trig_level = 10'd512;
      repeat (3) tick();
      start_capture("t3", a);
      wait_done("t3");
      check_capture(a, 1, 512, "t3");
      if (obs_q.size() > 0) chk("t3_first_ch1", obs_q[0].data & 32'h3ff, 512);

      // Falling crossing in mode 2 fires, in mode 1 it does not
      pat = 2; ramp = 530; bus.trig_mode = 2'd2;
      repeat (3) tick();
      start_capture("t3m2", a);
      wait_done("t3m2");
      check_capture(a, 2, 512, "t3m2");
      if (obs_q.size() > 0) chk("t3m2_first_ch1", obs_q[0].data & 32'h3ff, 511);

      pat = 2; ramp = 530; bus.trig_mode = 2'd1;
      repeat (3) tick();
      start_capture("t3fall", a);
      repeat (30) tick();
      chk("t3fall_nowr", obs_q.size(), 0);
      chk("t3fall_busy", bus.busy, 1);
      tick(1'b0, 1'b1);
      chk("t3fall_abort_busy", bus.busy, 0);
      chk("t3fall_abort_done", bus.done, 0);

      // A crossing seen only against the pre-arm sample must not fire
      pat = 3; hold_v = 100;
      repeat (3) tick();
      hold_v = 600;
      start_capture("t3first", a);
      repeat (10) tick();
      chk("t3first_nowr", obs_q.size(), 0);
      chk("t3first_busy", bus.busy, 1);
      tick(1'b0, 1'b1);
      chk("t3first_abort", bus.busy, 0);

      // T4: out-of-range counting, 3 hits then 5 hits (saturates)
      pat = 0; bus.trig_mode = 2'd0;
      start_capture("t4a", a);
      tick();
      otr_force = 1'b1; repeat (3) tick(); otr_force = 1'b0;
      wait_done("t4a");
      check_capture(a, 0, 0, "t4a");
      start_capture("t4b", a);
      tick();
      otr_force = 1'b1; repeat (5) tick(); otr_force = 1'b0;
      wait_done("t4b");
      check_capture(a, 0, 0, "t4b");

      // Randomized captures against the model
      pat = 0; otr_rand = 1'b1;
      for (int r = 0; r < 6; r++) begin
         mode = int'($urandom_range(0, 3));
         lvl = int'($urandom_range(100, 900));
         bus.trig_mode = 2'(mode);
         bus.trig_level = DATA_W'(lvl);
         repeat (2) tick();
         start_capture($sformatf("rnd%0d", r), a);
         wait_done($sformatf("rnd%0d", r));
         check_capture(a, mode, lvl, $sformatf("rnd%0d", r));
      end
      otr_rand = 1'b0;

      // T6a: lock lost from DONE clears done, no lock error
      bus.pll_lock = 1'b0;
      tick(); tick();
      chk("t6a_oe_still_on", bus.ad_oe_n, 0);
      tick();
      chk("t6a_oe_off", bus.ad_oe_n, 1);
      chk("t6a_done", bus.done, 0);
      chk("t6a_lock_err", bus.lock_err, 0);
      bus.pll_lock = 1'b1;
      repeat (LOCK_WAIT + 1) tick();
      chk("t6a_relock_wait", bus.ad_oe_n, 1);
      tick();
      chk("t6a_relock", bus.ad_oe_n, 0);

      // T5: abort at address 4, then start+abort together from IDLE
      bus.trig_mode = 2'd0;
      start_capture("t5", a);
      for (int i = 0; i < 20 && !(bus.wr_en === 1'b1 && bus.wr_addr === 4'd4); i++) tick();
      tick(1'b0, 1'b1);
      chk("t5_wr_en", bus.wr_en, 0);
      chk("t5_busy", bus.busy, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_addr_hold", bus.wr_addr, 4);
      chk("t5_nwr", obs_q.size(), 5);
      tick(1'b1, 1'b1);
      chk("t5_sa_busy", bus.busy, 0);
      tick();
      chk("t5_sa_busy2", bus.busy, 0);

      // T6b: lock lost mid-capture sets sticky lock_err; next start clears it
      start_capture("t6b", a);
      repeat (3) tick();
      bus.pll_lock = 1'b0;
      repeat (3) tick();
      chk("t6b_oe", bus.ad_oe_n, 1);
      chk("t6b_lock_err", bus.lock_err, 1);
      chk("t6b_wr_en", bus.wr_en, 0);
      chk("t6b_busy", bus.busy, 0);
      chk("t6b_done", bus.done, 0);
      bus.pll_lock = 1'b1;
      repeat (LOCK_WAIT + 2) tick();
      chk("t6b_relock", bus.ad_oe_n, 0);
      chk("t6b_err_sticky", bus.lock_err, 1);
      obs_q.delete();
      tick(1'b1);
      a = cyc;
      chk("t6b_err_clr", bus.lock_err, 0);
      chk("t6b_rearm", bus.busy, 1);
      wait_done("t6b");
      check_capture(a, 0, 0, "t6b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
